uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be:
  - NUM_REQ, default 4, number of requesters (2..8).
  - TIMEOUT_CYCLES, default 8192, WAIT watchdog limit in clk_50mhz cycles.
  - IDW, default clog2(NUM_REQ), width of the id field.
REQ-002 Ports SHALL be:
  - clk_50mhz  in   1          single clock, all logic on rising edge
  - reset      in   1          synchronous, active-high
  - req        in   NUM_REQ    per-requester send request, level
  - req_data   in   NUM_REQ*8  flattened bytes; requester i at [8i+7:8i]
  - gnt        out  NUM_REQ    one-hot, 1-cycle pulse: byte of requester i accepted
  - tx_start   out  1          1-cycle launch pulse to the UART transmitter
  - tx_data    out  8          byte to transmit, held stable from tx_start until tx_done
  - tx_busy    in   1          transmitter busy
  - tx_done    in   1          1-cycle pulse: transmitter finished the stop bit
  - active_id  out  IDW        id of the requester currently being served
  - busy       out  1          high in LAUNCH and WAIT
  - timeout_err out 1          1-cycle pulse on watchdog abort
REQ-003 Clock and reset are decided: one clock, clk_50mhz; reset is synchronous and active-high.

Function
REQ-010 FSM states SHALL be IDLE, LAUNCH and WAIT, with 2-bit encoding.
REQ-011 IDLE -> LAUNCH SHALL occur when |req==1 and tx_busy==0. On that edge the block latches winner into active_id and req_data[winner] into tx_data.
REQ-012 Winner SHALL be chosen round-robin: the first asserted req scanning upward from last_ptr+1, wrapping at NUM_REQ-1 to 0.
REQ-013 In LAUNCH, tx_start=1 and gnt[active_id]=1 for exactly one cycle; the next state is unconditionally WAIT.
REQ-014 Latency SHALL be: req sampled in IDLE -> tx_start and gnt high on the following cycle (one cycle).
REQ-015 WAIT -> IDLE SHALL occur on tx_done==1. On that edge last_ptr <= active_id.
REQ-016 A requester dropping req after the IDLE->LAUNCH edge SHALL NOT cancel the transfer; the latched byte is sent.
REQ-017 A requester holding req after gnt SHALL be treated as a new request. It is served again only after every other pending requester (fairness).
REQ-018 tx_done arriving in IDLE or LAUNCH SHALL be ignored.
REQ-019 If tx_busy==1 in IDLE, the block SHALL stay in IDLE regardless of req.
REQ-020 After tx_done, the earliest next tx_start SHALL be 2 cycles later (WAIT->IDLE->LAUNCH).
REQ-021 All outputs SHALL be registered; gnt, tx_start and timeout_err are never high in the same cycle as a different state's outputs.

Reset
REQ-030 Reset SHALL force:
  - state=IDLE
  - gnt=0, tx_start=0, tx_data=8'h00
  - active_id=0, busy=0, timeout_err=0
  - last_ptr=NUM_REQ-1, so requester 0 wins first
  - watchdog counter=0
REQ-031 Reset asserted in LAUNCH or WAIT SHALL abort the transfer without a gnt pulse. tx_start SHALL be 0 in the cycle after reset is sampled.

Configuration
REQ-040 Macro UART_ARB_TIMEOUT_EN SHALL control the watchdog.
  - Defined: a counter runs in WAIT and clears on entry to WAIT. If it reaches TIMEOUT_CYCLES-1 without tx_done, the block pulses timeout_err for one cycle, sets last_ptr <= active_id and returns to IDLE. tx_done in the same cycle as expiry takes priority: no error.
  - Not defined: WAIT exits only on tx_done, no counter is instantiated, and timeout_err is tied 0.

Structure
REQ-050 Package uart_pkg SHALL hold the FSM state encodings, CLK_FREQ=50000000, BAUD_RATE=115200 and the default TIMEOUT_CYCLES.
REQ-051 The round-robin search SHALL be one combinational sub-module, uart_rr_pick, with inputs req and last_ptr and outputs winner and valid.

Verification
REQ-060 Single request, no contention:
  - Stimulus: reset, then req=4'b0100, req_data[23:16]=8'hA5, tx_busy=0.
  - Response: next cycle gnt=4'b0100, tx_start=1, tx_data=8'hA5, active_id=2.
  - Completion: tx_done 4340 cycles later -> busy=0 on the next cycle.
REQ-061 Round-robin order:
  - Stimulus: req=4'b1111 held, tx_done pulsed 20 cycles after each tx_start.
  - Response: grant order 0,1,2,3,0.
REQ-062 Transmitter busy:
  - Stimulus: tx_busy=1 with req=4'b0001 for 50 cycles, then tx_busy=0.
  - Response: no tx_start while tx_busy=1; tx_start one cycle after tx_busy falls.
REQ-063 Request withdrawn:
  - Stimulus: req[1] high for one cycle only, data 8'h3C.
  - Response: byte 8'h3C still launched with gnt[1] pulse.
REQ-064 Reset mid-transfer:
  - Stimulus: reset pulsed in WAIT.
  - Response: all outputs at reset values next cycle; the following request from requester 0 wins.
REQ-065 Watchdog (UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16):
  - Stimulus: no tx_done after launch.
  - Response: timeout_err pulse 16 cycles after entering WAIT, then IDLE; the next requester in order is served.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants for the UART transmit arbiter slice.
//                Holds the arbiter FSM state encodings, the reference UART
//                timing (50 MHz clock, 115200 baud) and the default WAIT
//                watchdog limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Arbiter FSM state encodings (2-bit)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    // Reference UART timing
    localparam int CLK_FREQ  = 50000000;
    localparam int BAUD_RATE = 115200;

    // Clocks per bit and per 10-bit frame (start + 8 data + stop)
    localparam int BIT_CYCLES   = CLK_FREQ / BAUD_RATE;
    localparam int FRAME_CYCLES = 10 * BIT_CYCLES;

    // Default WAIT watchdog limit in clk_50mhz cycles
    localparam int DEF_TIMEOUT_CYCLES = 8192;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_pick
//  Description : Purely combinational round-robin search. Scans req upward
//                starting at last_ptr+1, wrapping from NUM_REQ-1 to 0, and
//                returns the first asserted index.
//  Ports       : req      in  NUM_REQ  request vector
//                last_ptr in  IDW      index served most recently
//                winner   out IDW      selected requester (0 when !valid)
//                valid    out 1        at least one request asserted
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_ptr,
    output logic [IDW-1:0]     winner,
    output logic               valid
);

    // (base + off) modulo NUM_REQ; off never exceeds NUM_REQ, so a single
    // conditional subtraction is enough.
    function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base,
                                              input int             off);
        int v_sum;
        v_sum = int'(base) + off;
        if (v_sum >= NUM_REQ) begin
            v_sum = v_sum - NUM_REQ;
        end
        return v_sum[IDW-1:0];
    endfunction

    // Walk from the farthest candidate to the nearest so that the nearest
    // asserted request (lowest offset from last_ptr) is the final assignment.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (req[f_wrap(last_ptr, off)]) begin
                winner = f_wrap(last_ptr, off);
                valid  = 1'b1;
            end
        end
    end

endmodule : uart_rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one UART transmitter among
//                NUM_REQ byte sources. IDLE picks a winner when the
//                transmitter is free, LAUNCH issues a one-cycle tx_start and
//                gnt pulse, WAIT holds the byte until tx_done.
//  Config      : `define UART_ARB_TIMEOUT_EN enables a WAIT watchdog that
//                aborts after TIMEOUT_CYCLES cycles without tx_done and
//                pulses timeout_err. Undefined: no counter, timeout_err = 0.
//  Ports       : clk_50mhz   in   1          clock, rising edge
//                reset       in   1          synchronous, active-high
//                req         in   NUM_REQ    per-requester level request
//                req_data    in   NUM_REQ*8  requester i byte at [8i+7:8i]
//                gnt         out  NUM_REQ    one-hot accept pulse
//                tx_start    out  1          transmitter launch pulse
//                tx_data     out  8          byte to transmit
//                tx_busy     in   1          transmitter busy
//                tx_done     in   1          transmitter finished pulse
//                active_id   out  IDW        requester being served
//                busy        out  1          high in LAUNCH and WAIT
//                timeout_err out  1          watchdog abort pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int IDW            = $clog2(NUM_REQ)
) (
    input  logic                 clk_50mhz,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [IDW-1:0]       active_id,
    output logic                 busy,
    output logic                 timeout_err
);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [IDW-1:0]     r_last_ptr;
    logic [IDW-1:0]     r_active_id;
    logic [7:0]         r_tx_data;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_tx_start;
    logic               r_busy;
    logic               r_timeout_err;

    logic [IDW-1:0]     w_winner;
    logic               w_valid;
    logic               w_wd_expire;
    logic               w_launch;
    logic               w_wait_exit;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic               w_tx_start_nxt;
    logic               w_busy_nxt;
    logic               w_timeout_nxt;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req      (req),
        .last_ptr (r_last_ptr),
        .winner   (w_winner),
        .valid    (w_valid)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_WD_W-1:0] r_wd_cnt;

    // Held at zero outside WAIT, so each WAIT visit starts counting from 0.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
        end
    end

    assign w_wd_expire = (r_state == ST_WAIT) &&
                         (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_wd_expire = 1'b0;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_valid && !tx_busy) begin
                    w_next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done || w_wd_expire) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Outputs are computed one cycle ahead and registered, so tx_start/gnt
    // appear exactly during the LAUNCH cycle and timeout_err during the
    // first IDLE cycle after an abort.
    always_comb begin
        w_launch       = (r_state == ST_IDLE) && (w_next_state == ST_LAUNCH);
        w_wait_exit    = (r_state == ST_WAIT) && (w_next_state == ST_IDLE);
        w_gnt_nxt      = w_launch ? (NUM_REQ'(1) << w_winner) : '0;
        w_tx_start_nxt = w_launch;
        w_busy_nxt     = (w_next_state != ST_IDLE);
        // tx_done in the expiry cycle wins: the transfer completed normally.
        w_timeout_nxt  = w_wait_exit && !tx_done;
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_gnt         <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_active_id   <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            // Pointer parked at the top so requester 0 wins first.
            r_last_ptr    <= IDW'(NUM_REQ - 1);
        end else begin
            r_gnt         <= w_gnt_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout_err <= w_timeout_nxt;
            if (w_launch) begin
                r_active_id <= w_winner;
                r_tx_data   <= req_data[{w_winner, 3'b000} +: 8];
            end
            if (w_wait_exit) begin
                r_last_ptr <= r_active_id;
            end
        end
    end

    assign gnt         = r_gnt;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign active_id   = r_active_id;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter
//                (NUM_REQ=4, TIMEOUT_CYCLES=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        clk_50mhz = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  active_id;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_50mhz   (clk_50mhz),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .active_id   (active_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    task automatic step();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_xfer();
        repeat (3) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL tb_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int  n;
        int  cnt;
        bit  found;
        bit  saw;

        reset    = 1'b1;
        req      = 4'b0000;
        req_data = 32'h0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_gnt",      {28'd0, gnt},         32'd0);
        chk("rst_tx_start", {31'd0, tx_start},    32'd0);
        chk("rst_tx_data",  {24'd0, tx_data},     32'd0);
        chk("rst_active",   {30'd0, active_id},   32'd0);
        chk("rst_busy",     {31'd0, busy},        32'd0);
        chk("rst_timeout",  {31'd0, timeout_err}, 32'd0);

        // Single request, requester 2, byte A5
        req      = 4'b0100;
        req_data = 32'h11A52233;
        step();
        req = 4'b0000;
        chk("single_gnt",      {28'd0, gnt},       32'h4);
        chk("single_tx_start", {31'd0, tx_start},  32'd1);
        chk("single_tx_data",  {24'd0, tx_data},   32'hA5);
        chk("single_active",   {30'd0, active_id}, 32'd2);
        chk("single_busy",     {31'd0, busy},      32'd1);
        step();
        chk("single_start_1cyc", {31'd0, tx_start}, 32'd0);
        chk("single_gnt_1cyc",   {28'd0, gnt},      32'd0);
        repeat (4337) step();
        chk("single_hold_data", {24'd0, tx_data}, 32'hA5);
        chk("single_wait_busy", {31'd0, busy},    32'd1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("single_done_busy", {31'd0, busy}, 32'd0);

        // Round-robin order 0,1,2,3,0 from a fresh reset
        reset = 1'b1;
        step();
        reset    = 1'b0;
        req      = 4'b1111;
        req_data = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            n     = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                n++;
                if (tx_start) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("rr_launch_seen", {31'd0, found},     32'd1);
            chk("rr_active",      {30'd0, active_id}, k % 4);
            chk("rr_gnt",         {28'd0, gnt},       32'd1 << (k % 4));
            chk("rr_data",        {24'd0, tx_data},   32'h11 * ((k % 4) + 1));
            if (k > 0) begin
                chk("rr_done_to_start", n, 32'd1);
            end
            repeat (19) step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
        end
        req = 4'b0000;
        step();

        // Transmitter busy blocks launch
        req     = 4'b0001;
        tx_busy = 1'b1;
        cnt     = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tx_start) cnt++;
        end
        chk("busy_no_start", cnt, 32'd0);
        chk("busy_idle",     {31'd0, busy}, 32'd0);
        tx_busy = 1'b0;
        step();
        chk("busy_release_start", {31'd0, tx_start}, 32'd1);
        chk("busy_release_gnt",   {28'd0, gnt},      32'h1);
        // tx_done during LAUNCH must be ignored
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        req     = 4'b0000;
        chk("done_in_launch_ignored", {31'd0, busy}, 32'd1);
        finish_xfer();

        // Request withdrawn after one cycle still launches
        req      = 4'b0010;
        req_data = 32'h55663C77;
        step();
        req = 4'b0000;
        chk("withdraw_gnt",    {28'd0, gnt},       32'h2);
        chk("withdraw_data",   {24'd0, tx_data},   32'h3C);
        chk("withdraw_active", {30'd0, active_id}, 32'd1);
        finish_xfer();

        // Reset pulsed in WAIT
        req = 4'b1000;
        step();
        req = 4'b0000;
        chk("rstmid_active_pre", {30'd0, active_id}, 32'd3);
        step();
        step();
        reset = 1'b1;
        step();
        chk("rstmid_gnt",      {28'd0, gnt},       32'd0);
        chk("rstmid_tx_start", {31'd0, tx_start},  32'd0);
        chk("rstmid_busy",     {31'd0, busy},      32'd0);
        chk("rstmid_active",   {30'd0, active_id}, 32'd0);
        chk("rstmid_tx_data",  {24'd0, tx_data},   32'd0);
        reset = 1'b0;
        req   = 4'b1001;
        step();
        req = 4'b0000;
        chk("rstmid_next_active", {30'd0, active_id}, 32'd0);
        chk("rstmid_next_gnt",    {28'd0, gnt},       32'h1);
        finish_xfer();

        // Watchdog behaviour (requester 1 launched, no tx_done)
        req = 4'b0110;
        step();
        req = 4'b0000;
        chk("wd_launch_active", {30'd0, active_id}, 32'd1);
        step();
`ifdef UART_ARB_TIMEOUT_EN
        found = 1'b0;
        n     = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (timeout_err) begin
                found = 1'b1;
                break;
            end
        end
        chk("wd_timeout_seen",  {31'd0, found}, 32'd1);
        chk("wd_timeout_cycle", n,              32'd16);
        chk("wd_timeout_idle",  {31'd0, busy},  32'd0);
        step();
        chk("wd_timeout_pulse", {31'd0, timeout_err}, 32'd0);
`else
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (timeout_err) saw = 1'b1;
        end
        chk("nowd_no_timeout", {31'd0, saw},  32'd0);
        chk("nowd_still_busy", {31'd0, busy}, 32'd1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("nowd_done_idle", {31'd0, busy}, 32'd0);
`endif
        req = 4'b0110;
        step();
        req = 4'b0000;
        chk("wd_next_active", {30'd0, active_id}, 32'd2);
        chk("wd_next_gnt",    {28'd0, gnt},       32'h4);
        finish_xfer();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
